// File: rtl/io_port_pkg.sv
// io_port_pkg: shared defaults and derived widths for the buffered I/O port.
package io_port_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int PTR_W      = $clog2(DEPTH_DEF);
    localparam int CNT_W      = PTR_W + 1;
endpackage

// File: rtl/io_port_buffered_sync_fifo.sv
// sync_fifo: first-word fall-through circular FIFO with a same-cycle push/pop.
module sync_fifo
    import io_port_pkg::*;
#(
    parameter int W     = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Never expose stale storage while empty.
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (do_pop)  rptr_d = rptr_q + PW'(1);
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
        if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/io_port_buffered.sv
// io_port_buffered: output/input FIFOs between the datapath bus and a device,
// with sticky overflow/underflow flags.
module io_port_buffered
    import io_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              out_wr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] dev_data,
    input  logic              dev_valid,
    output logic              dev_ready,
    input  logic              in_rd,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic              out_full,
    output logic              ovf,
    output logic              udf,
    input  logic              err_clr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0] out_cnt, in_cnt;
    logic          out_fifo_full, out_empty;
    logic          in_full, in_empty;
    logic          in_pop, out_pop;
    logic          ovf_q, ovf_d, udf_q, udf_d;

    assign out_valid = !out_empty;
    assign out_full  = (out_cnt == CW'(DEPTH));
    assign in_valid  = (in_cnt != '0);
    assign out_pop   = out_valid && out_ready;
    assign in_pop    = in_rd && !in_empty;
    // A full input FIFO may refill in the same cycle it is read.
    assign dev_ready = !in_full || in_pop;

    sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (out_wr),
        .pop   (out_ready),
        .wdata (bus_in),
        .rdata (out_data),
        .count (out_cnt),
        .full  (out_fifo_full),
        .empty (out_empty)
    );

    sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (dev_valid && dev_ready),
        .pop   (in_rd),
        .wdata (dev_data),
        .rdata (in_data),
        .count (in_cnt),
        .full  (in_full),
        .empty (in_empty)
    );

    always_comb begin
        ovf_d = ovf_q | (out_wr && out_fifo_full && !out_pop);
        udf_d = udf_q | (in_rd && in_empty);
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
endmodule

// File: tb/tb_io_port_buffered.sv
// tb_io_port_buffered: directed checks of both FIFOs, flags and reset.
module tb_io_port_buffered;
    logic        clk = 1'b0;
    logic        clr, out_wr, out_ready, dev_valid, in_rd, err_clr;
    logic [31:0] bus_in, dev_data;
    logic [31:0] out_data, in_data;
    logic        out_valid, dev_ready, in_valid, out_full, ovf, udf;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    io_port_buffered dut (
        .clk       (clk),
        .clr       (clr),
        .bus_in    (bus_in),
        .out_wr    (out_wr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dev_data  (dev_data),
        .dev_valid (dev_valid),
        .dev_ready (dev_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_full  (out_full),
        .ovf       (ovf),
        .udf       (udf),
        .err_clr   (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        clr = 0; out_wr = 0; out_ready = 0; dev_valid = 0;
        in_rd = 0; err_clr = 0; bus_in = '0; dev_data = '0;
    endtask

    initial begin
        idle();
        clr = 1;
        tick();
        clr = 0;
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst in_valid", 32'(in_valid), 0);
        chk("rst out_full", 32'(out_full), 0);
        chk("rst dev_ready", 32'(dev_ready), 1);
        chk("rst ovf", 32'(ovf), 0);
        chk("rst udf", 32'(udf), 0);
        chk("rst out_data", out_data, 0);
        chk("rst in_data", in_data, 0);

        // Three words, device stalled, then drained.
        out_wr = 1;
        bus_in = 32'h11; tick();
        bus_in = 32'h22; tick();
        bus_in = 32'h33; tick();
        out_wr = 0;
        #1;
        chk("fwft out_valid", 32'(out_valid), 1);
        chk("fwft out_data", out_data, 32'h11);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain out_data", out_data, 32'h11 * (i + 1));
            tick();
        end
        out_ready = 0;
        #1;
        chk("drain empty", 32'(out_valid), 0);
        chk("drain empty data", out_data, 0);

        // Fill, overflow, then full push with same-cycle pop.
        out_wr = 1;
        for (int i = 0; i < 4; i++) begin
            bus_in = 32'h41 + i;
            tick();
        end
        #1;
        chk("fill out_full", 32'(out_full), 1);
        bus_in = 32'h55;
        tick();
        #1;
        chk("ovf set", 32'(ovf), 1);
        chk("ovf full", 32'(out_full), 1);
        chk("ovf head", out_data, 32'h41);
        out_ready = 1;
        tick();
        out_wr = 0;
        out_ready = 0;
        #1;
        chk("push+pop full", 32'(out_full), 1);
        chk("push+pop ovf", 32'(ovf), 1);
        chk("push+pop head", out_data, 32'h42);
        err_clr = 1;
        tick();
        err_clr = 0;
        #1;
        chk("ovf cleared", 32'(ovf), 0);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ovf drain", out_data, (i == 3) ? 32'h55 : 32'h42 + i);
            tick();
        end
        out_ready = 0;
        #1;
        chk("ovf drain empty", 32'(out_valid), 0);

        // Input FIFO fill and read.
        dev_valid = 1;
        for (int i = 0; i < 4; i++) begin
            dev_data = 32'hA0 + i;
            #1;
            chk("dev_ready fill", 32'(dev_ready), 1);
            tick();
        end
        dev_valid = 0;
        #1;
        chk("in full ready", 32'(dev_ready), 0);
        chk("in valid", 32'(in_valid), 1);
        in_rd = 1;
        #1;
        chk("refill ready", 32'(dev_ready), 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("in_data", in_data, 32'hA0 + i);
            tick();
        end
        in_rd = 0;
        #1;
        chk("in empty", 32'(in_valid), 0);
        chk("in empty data", in_data, 0);

        // Underflow and err_clr priority.
        in_rd = 1;
        #1;
        chk("udf data", in_data, 0);
        tick();
        #1;
        chk("udf set", 32'(udf), 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        in_rd = 0;
        #1;
        chk("udf clr prio", 32'(udf), 0);

        // Pointer wrap streaming, output side.
        out_ready = 1;
        out_wr = 1;
        for (int i = 0; i < 10; i++) begin
            bus_in = 32'h100 + i;
            #1;
            if (i > 0) chk("stream out", out_data, 32'h100 + i - 1);
            chk("stream out nfull", 32'(out_full), 0);
            tick();
        end
        out_wr = 0;
        #1;
        chk("stream out last", out_data, 32'h109);
        tick();
        out_ready = 0;
        #1;
        chk("stream out done", 32'(out_valid), 0);

        // Pointer wrap streaming, input side.
        dev_valid = 1;
        for (int i = 0; i < 10; i++) begin
            dev_data = 32'h200 + i;
            in_rd = (i > 0);
            #1;
            if (i > 0) chk("stream in", in_data, 32'h200 + i - 1);
            tick();
        end
        dev_valid = 0;
        #1;
        chk("stream in last", in_data, 32'h209);
        tick();
        in_rd = 0;
        #1;
        chk("stream in done", 32'(in_valid), 0);
        chk("stream in udf", 32'(udf), 0);

        // clr with data in flight.
        out_wr = 1;
        dev_valid = 1;
        bus_in = 32'h77; dev_data = 32'h88; tick();
        bus_in = 32'h78; dev_data = 32'h89; tick();
        out_wr = 0;
        dev_valid = 0;
        in_rd = 1;
        tick();
        in_rd = 1;
        tick();
        in_rd = 1;
        tick();
        in_rd = 0;
        out_wr = 1;
        bus_in = 32'h90; tick();
        bus_in = 32'h91; tick();
        out_wr = 0;
        dev_valid = 1;
        dev_data = 32'h92; tick();
        dev_data = 32'h93; tick();
        dev_valid = 0;
        #1;
        chk("pre-clr udf", 32'(udf), 1);
        chk("pre-clr in", in_data, 32'h92);
        clr = 1;
        tick();
        clr = 0;
        #1;
        chk("clr out_valid", 32'(out_valid), 0);
        chk("clr in_valid", 32'(in_valid), 0);
        chk("clr dev_ready", 32'(dev_ready), 1);
        chk("clr ovf", 32'(ovf), 0);
        chk("clr udf", 32'(udf), 0);
        chk("clr out_data", out_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
